// File: rtl/led_arb_pkg.sv
// Shared constants, FSM encoding and pattern helpers for the LED status arbiter.
// Pattern timing is expressed in 1 ms ticks.
package led_arb_pkg;

    localparam logic [1:0] MODE_SOLID = 2'b00;
    localparam logic [1:0] MODE_SLOW  = 2'b01;
    localparam logic [1:0] MODE_FAST  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam int SLOW_HALF_MS = 500;
    localparam int FAST_HALF_MS = 125;
    localparam int BURST_ON_MS  = 200;
    localparam int BURST_GAP_MS = 1000;
    localparam int HB_HALF_MS   = 1000;

    // Longest period is a 7-pulse burst: 7*400+1000 = 3800 ticks.
    localparam int PHASE_W = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    function automatic int burst_count(input logic [2:0] code);
        return (code == 3'd0) ? 1 : int'(code);
    endfunction

    function automatic logic [PHASE_W-1:0] pattern_period(input logic [1:0] mode,
                                                         input logic [2:0] code);
        case (mode)
            MODE_SLOW:  return PHASE_W'(2 * SLOW_HALF_MS);
            MODE_FAST:  return PHASE_W'(2 * FAST_HALF_MS);
            MODE_BURST: return PHASE_W'(burst_count(code) * 2 * BURST_ON_MS + BURST_GAP_MS);
            default:    return PHASE_W'(1);
        endcase
    endfunction

    function automatic logic pattern_on(input logic [1:0] mode, input logic [2:0] code,
                                        input logic [PHASE_W-1:0] phase);
        logic on;
        on = 1'b0;
        case (mode)
            MODE_SOLID: on = 1'b1;
            MODE_SLOW:  on = (int'(phase) < SLOW_HALF_MS);
            MODE_FAST:  on = (int'(phase) < FAST_HALF_MS);
            default: begin
                for (int k = 0; k < 7; k++) begin
                    if (k < burst_count(code) &&
                        int'(phase) >= k * 2 * BURST_ON_MS &&
                        int'(phase) <  k * 2 * BURST_ON_MS + BURST_ON_MS)
                        on = 1'b1;
                end
            end
        endcase
        return on;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a registered 1-cycle tick every DIV clocks,
// plus the free-running heartbeat that toggles every HB_HALF_MS ticks.
module led_tick_gen
    import led_arb_pkg::*;
#(
    parameter int DIV = 100_000
)(
    input  logic clk_100M,
    input  logic rst_n,
    output logic tick,
    output logic hb_led
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HB_W  = $clog2(HB_HALF_MS);

    logic [CNT_W-1:0] cnt;
    logic [HB_W-1:0]  hb_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tick   <= 1'b0;
            hb_cnt <= '0;
            hb_led <= 1'b1;
        end else begin
            tick <= (cnt == CNT_W'(DIV - 1));
            cnt  <= (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + 1'b1;
            if (tick) begin
                if (hb_cnt == HB_W'(HB_HALF_MS - 1)) begin
                    hb_cnt <= '0;
                    hb_led <= ~hb_led;
                end else begin
                    hb_cnt <= hb_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_status_arb.sv
// Shares two board LEDs: led[0] heartbeat, led[1] pattern of the highest-priority requester
// with a minimum hold time. Optional `LED_PWM_EN dims the led[1] on-phase with a 1/16-step duty.
module led_status_arb
    import led_arb_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int NREQ        = 4,
    parameter int MIN_HOLD_MS = 500
`ifdef LED_PWM_EN
    ,parameter int PWM_DUTY   = 4
`endif
)(
    input  logic              clk_100M,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_mode,
    input  logic [3*NREQ-1:0] req_code,
    output logic [NREQ-1:0]   grant,
    output logic [1:0]        led
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = $clog2(MIN_HOLD_MS + 1);

    logic                tick;
    logic                hb_led;
    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_d;
    logic [1:0]          mode_q, mode_d;
    logic [2:0]          code_q, code_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                led1_q, led1_d;
    logic [IDX_W-1:0]    pick_idx;
    logic [NREQ-1:0]     pick_oh;
    logic                relatch;
    logic                hold_done;
    logic                pwm_on;

    led_tick_gen #(.DIV(CLK_FREQ_HZ / TICK_HZ)) u_tick_gen (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .tick     (tick),
        .hb_led   (hb_led)
    );

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;
    end
    assign pwm_on = (5'(pwm_cnt) < 5'(PWM_DUTY));
`else
    assign pwm_on = 1'b1;
`endif

    // Lowest set index wins.
    always_comb begin
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) pick_idx = IDX_W'(i);
        end
        pick_oh = (|req) ? (NREQ'(1) << pick_idx) : '0;
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant   <= '0;
            mode_q  <= MODE_SOLID;
            code_q  <= '0;
            phase_q <= '0;
            hold_q  <= '0;
            led1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            mode_q  <= mode_d;
            code_q  <= code_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            led1_q  <= led1_d;
        end
    end

    assign hold_done = (hold_q >= HOLD_W'(MIN_HOLD_MS));

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        grant_d = grant;
        mode_d  = mode_q;
        code_d  = code_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        relatch = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_d = ST_SHOW;
                        relatch = 1'b1;
                    end
                end
                default: begin
                    if (hold_done && !(|req)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        phase_d = '0;
                        hold_d  = '0;
                    end else if (hold_done && pick_oh != grant) begin
                        relatch = 1'b1;
                    end else begin
                        hold_d  = hold_done ? hold_q : hold_q + 1'b1;
                        phase_d = (phase_q == pattern_period(mode_q, code_q) - PHASE_W'(1))
                                  ? '0 : phase_q + 1'b1;
                    end
                end
            endcase
        end
        if (relatch) begin
            grant_d = pick_oh;
            mode_d  = req_mode[2*pick_idx +: 2];
            code_d  = req_code[3*pick_idx +: 3];
            phase_d = '0;
            hold_d  = '0;
        end
    end

    always_comb begin
        led1_d = (state_d == ST_SHOW) && pattern_on(mode_d, code_d, phase_d) && pwm_on;
    end

    assign led = {led1_q, hb_led};

endmodule

// File: tb/tb_led_status_arb.sv
// Directed bench for led_status_arb with a 10-clock tick; expected edges are hand-computed
// relative to reset release (tick k is seen by the FSM on edge 10k+1).
module tb_led_status_arb;

    logic        clk_100M = 1'b0;
    logic        rst_n    = 1'b0;
    logic [3:0]  req      = '0;
    logic [7:0]  req_mode = '0;
    logic [11:0] req_code = '0;
    logic [3:0]  grant;
    logic [1:0]  led;

    int total = 0;
    int bad   = 0;
    int cyc_abs = 0;
    int base    = 0;

    always #5 clk_100M = ~clk_100M;
    always @(posedge clk_100M) cyc_abs <= cyc_abs + 1;

    led_status_arb #(
        .CLK_FREQ_HZ (10_000),
        .TICK_HZ     (1000),
        .NREQ        (4),
        .MIN_HOLD_MS (500)
    ) dut (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .req      (req),
        .req_mode (req_mode),
        .req_code (req_code),
        .grant    (grant),
        .led      (led)
    );

    task automatic do_reset(input logic [3:0] r, input logic [7:0] m, input logic [11:0] c);
        @(negedge clk_100M);
        rst_n    = 1'b0;
        req      = r;
        req_mode = m;
        req_code = c;
        repeat (3) @(negedge clk_100M);
        rst_n = 1'b1;
        base  = cyc_abs;
    endtask

    // Returns at the negedge following posedge number k after reset release.
    task automatic run_to(input int k);
        while (cyc_abs < base + k) @(negedge clk_100M);
    endtask

    task automatic test_reset_heartbeat();
        do_reset(4'b0000, 8'h00, 12'h000);
        run_to(1);
        total++; if (led !== 2'b01) begin bad++; $display("FAIL reset_led: got %b want 01", led); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        run_to(10000);
        total++; if (led[0] !== 1'b1) begin bad++; $display("FAIL hb_before_toggle: got %b want 1", led[0]); end
        run_to(10001);
        total++; if (led[0] !== 1'b0) begin bad++; $display("FAIL hb_toggle1: got %b want 0", led[0]); end
        run_to(20000);
        total++; if (led[0] !== 1'b0) begin bad++; $display("FAIL hb_before_toggle2: got %b want 0", led[0]); end
        run_to(20001);
        total++; if (led !== 2'b01) begin bad++; $display("FAIL hb_toggle2_idle: got %b want 01", led); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL idle_grant: got %b want 0000", grant); end
    endtask

    task automatic test_slow_blink();
        do_reset(4'b0100, 8'b00_01_00_00, 12'h000);
        run_to(10);
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL slow_pre_tick_grant: got %b want 0000", grant); end
        run_to(11);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL slow_grant: got %b want 0100", grant); end
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL slow_starts_on: got %b want 1", led[1]); end
        run_to(5010);
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL slow_on_end: got %b want 1", led[1]); end
        run_to(5011);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL slow_off_start: got %b want 0", led[1]); end
        run_to(6000);
        req_mode = 8'h00;
        run_to(10010);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL slow_mode_change_ignored: got %b want 0", led[1]); end
        run_to(10011);
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL slow_wrap_on: got %b want 1", led[1]); end
    endtask

    task automatic test_hold_and_burst();
        int e;
        do_reset(4'b1000, 8'b00_00_00_11, 12'b000_000_000_011);
        run_to(11);
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL hold_grant3: got %b want 1000", grant); end
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL hold_solid_on: got %b want 1", led[1]); end
        run_to(1011);
        req = 4'b1001;
        run_to(5020);
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL hold_kept: got %b want 1000", grant); end
        run_to(5021);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL hold_switch: got %b want 0001", grant); end
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL burst_starts_on: got %b want 1", led[1]); end
        e = 5021;
        run_to(e + 1999);
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL burst_p1_end: got %b want 1", led[1]); end
        run_to(e + 2000);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL burst_p1_off: got %b want 0", led[1]); end
        run_to(e + 3999);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL burst_gap1_end: got %b want 0", led[1]); end
        run_to(e + 4000);
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL burst_p2_on: got %b want 1", led[1]); end
        run_to(e + 8000);
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL burst_p3_on: got %b want 1", led[1]); end
        run_to(e + 10000);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL burst_long_gap: got %b want 0", led[1]); end
        run_to(e + 21999);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL burst_period_end: got %b want 0", led[1]); end
        run_to(e + 22000);
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL burst_period_wrap: got %b want 1", led[1]); end
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL burst_grant_kept: got %b want 0001", grant); end
    endtask

    task automatic test_burst_code0();
        do_reset(4'b0001, 8'b00_00_00_11, 12'h000);
        run_to(11);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL code0_grant: got %b want 0001", grant); end
        run_to(2010);
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL code0_pulse_end: got %b want 1", led[1]); end
        run_to(2011);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL code0_off: got %b want 0", led[1]); end
        run_to(14010);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL code0_period_end: got %b want 0", led[1]); end
        run_to(14011);
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL code0_wrap: got %b want 1", led[1]); end
    endtask

    task automatic test_req_drop();
        do_reset(4'b0010, 8'b00_00_10_00, 12'h000);
        run_to(11);
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL drop_grant: got %b want 0010", grant); end
        run_to(511);
        req = 4'b0000;
        run_to(1261);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL drop_fast_off: got %b want 0", led[1]); end
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL drop_grant_held: got %b want 0010", grant); end
        run_to(2511);
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL drop_fast_wrap: got %b want 1", led[1]); end
        run_to(5020);
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL drop_last_held: got %b want 0010", grant); end
        run_to(5021);
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL drop_idle_grant: got %b want 0000", grant); end
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL drop_idle_led: got %b want 0", led[1]); end
    endtask

    task automatic test_async_reset();
        do_reset(4'b0001, 8'b00_00_00_11, 12'd2);
        run_to(50);
        total++; if (led !== 2'b11) begin bad++; $display("FAIL mid_burst_led: got %b want 11", led); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (led !== 2'b01) begin bad++; $display("FAIL async_rst_led: got %b want 01", led); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL async_rst_grant: got %b want 0000", grant); end
        @(negedge clk_100M);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset_heartbeat();
        test_slow_blink();
        test_hold_and_burst();
        test_burst_code0();
        test_req_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
